alu_arbiter: RTL and testbench

Shares the single 16-bit ALU (ops 00 add, 01 sub, 10 and, 11 not-B; flags {zero, negative, overflow}) between NREQ independent requesters, such as the datapath execute stage and the address/branch unit. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request at a time and drives the ALU from registered operands. The registered result, flags and requester id are returned on a valid/ready response channel. The block sits beside the ALU at the CPU top level.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encoding, flag bit positions and the
// ALU arbiter state type.
package cpu_pkg;

   typedef enum logic [1:0] {
      ADD  = 2'b00,
      SUB  = 2'b01,
      AND  = 2'b10,
      NOTB = 2'b11
   } alu_op_t;

   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or above ptr,
// wrapping to bit 0. Shared with the memory-port arbiter.
module rr_pick #(
   parameter int N  = 2,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   logic [PW-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = PW'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the single ALU between NREQ requesters; the result
// is captured and returned with the requester id on a valid/ready channel.
module alu_arbiter
   import cpu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 16,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_ain,
   input  logic [NREQ*W-1:0] req_bin,
   input  logic [NREQ*2-1:0] req_op,
   output logic [W-1:0]      alu_ain,
   output logic [W-1:0]      alu_bin,
   output logic [1:0]        alu_op,
   input  logic [W-1:0]      alu_out,
   input  logic [2:0]        alu_z,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [W-1:0]      resp_out,
   output logic [2:0]        resp_z,
   output logic [IW-1:0]     resp_id,
   output logic              busy
);

   arb_state_t    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] id_q, id_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   alu_op_t       op_q, op_d;
   logic [W-1:0]  out_q, out_d;
   logic [2:0]    z_q, z_d;

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gidx;
   logic            gany;

   rr_pick #(.N(NREQ), .PW(IW)) u_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gidx),
      .any (gany)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      out_d     = out_q;
      z_d       = z_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (gany) begin
               req_ready = gnt;
               a_d       = req_ain[gidx*W +: W];
               b_d       = req_bin[gidx*W +: W];
               op_d      = alu_op_t'(req_op[gidx*2 +: 2]);
               id_d      = gidx;
               ptr_d     = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            out_d   = alu_out;
            z_d     = alu_z;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= ADD;
         out_q   <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         out_q   <= out_d;
         z_q     <= z_d;
      end
   end

   // Operand registers drive the ALU continuously so its inputs only move on a grant.
   assign alu_ain    = a_q;
   assign alu_bin    = b_q;
   assign alu_op     = op_q;
   assign resp_valid = (state_q == RESP);
   assign resp_out   = out_q;
   assign resp_z     = z_q;
   assign resp_id    = id_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
   import cpu_pkg::*;

   localparam int NREQ = 2;
   localparam int W    = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_ain, req_bin;
   logic [NREQ*2-1:0] req_op;
   logic [W-1:0]      alu_ain, alu_bin, alu_out;
   logic [1:0]        alu_op;
   logic [2:0]        alu_z;
   logic              resp_valid, resp_ready;
   logic [W-1:0]      resp_out;
   logic [2:0]        resp_z;
   logic [0:0]        resp_id;
   logic              busy;

   typedef struct {
      logic [W-1:0] out;
      logic [2:0]   z;
      int           id;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ain(req_ain), .req_bin(req_bin), .req_op(req_op),
      .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
      .alu_out(alu_out), .alu_z(alu_z),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_out(resp_out), .resp_z(resp_z), .resp_id(resp_id),
      .busy(busy)
   );

   // Behavioural ALU standing in for the CPU's combinational ALU
   always_comb begin
      alu_out = '0;
      alu_z   = '0;
      case (alu_op)
         2'b00: begin
            alu_out       = alu_ain + alu_bin;
            alu_z[FLAG_V] = (alu_ain[W-1] == alu_bin[W-1]) && (alu_out[W-1] != alu_ain[W-1]);
         end
         2'b01: begin
            alu_out       = alu_ain - alu_bin;
            alu_z[FLAG_V] = (alu_ain[W-1] != alu_bin[W-1]) && (alu_out[W-1] != alu_ain[W-1]);
         end
         2'b10:   alu_out = alu_ain & alu_bin;
         default: alu_out = ~alu_bin;
      endcase
      alu_z[FLAG_Z] = (alu_out == '0);
      alu_z[FLAG_N] = alu_out[W-1];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && resp_valid && resp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got out=0x%0h id=%0d expected none", resp_out, resp_id);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_out", 32'(resp_out), 32'(e.out));
            check("resp_z",   32'(resp_z),   32'(e.z));
            check("resp_id",  32'(resp_id),  32'(e.id));
         end
      end
   end

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      req_ain[i*W +: W] = a;
      req_bin[i*W +: W] = b;
      req_op[i*2 +: 2]  = op;
   endtask

   // Called just after a rising edge; returns just after the edge that leaves RESP is due.
   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [W-1:0] eo, input logic [2:0] ez);
      exp_t e;
      bit   got = 0;
      set_req(i, a, b, op);
      req_valid[i] = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (req_ready[i]) got = 1;
         else begin @(posedge clk); #1; end
      end
      check("grant_seen", 32'(got), 32'd1);
      e.out = eo; e.z = ez; e.id = i;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      @(negedge clk);
      check("exec_no_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      check("latency_valid", 32'(resp_valid), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   int order[4] = '{0, 1, 0, 1};
   exp_t cexp[2];

   initial begin
      req_valid = '0; req_ain = '0; req_bin = '0; req_op = '0; resp_ready = 1'b1;
      reset_n = 1'b0;
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp_out", 32'(resp_out), 32'd0);
      check("rst_resp_z", 32'(resp_z), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
      check("rst_alu_ain", 32'(alu_ain), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;

      // Single request: overflow on 0x8000 - 1
      issue(0, 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 3'b001);
      @(negedge clk);
      check("alu_ain_hold", 32'(alu_ain), 32'h8000);
      check("alu_op_hold", 32'(alu_op), 32'd1);
      @(posedge clk); #1;

      // Zero result, then NOT-B
      issue(1, 16'h0005, 16'h0005, 2'b01, 16'h0000, 3'b100);
      issue(1, 16'h1234, 16'h0000, 2'b11, 16'hFFFF, 3'b010);

      // Contention from reset
      do_reset();
      cexp[0].out = 16'h0007; cexp[0].z = 3'b000; cexp[0].id = 0;
      cexp[1].out = 16'h00F0; cexp[1].z = 3'b000; cexp[1].id = 1;
      set_req(0, 16'h0003, 16'h0004, 2'b00);
      set_req(1, 16'hF0F0, 16'h0FF0, 2'b10);
      req_valid = 2'b11;
      begin
         int n = 0;
         for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            check("onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (req_ready != 0) begin
               int g;
               g = req_ready[1] ? 1 : 0;
               check("grant_order", 32'(g), 32'(order[n]));
               sb.push_back(cexp[g]);
               n++;
            end
         end
         check("contention_grants", 32'(n), 32'd4);
      end
      @(posedge clk); #1 req_valid = '0;
      repeat (4) @(posedge clk); #1;

      // Back-pressure: response held, no grants to a waiting requester
      resp_ready = 1'b0;
      issue(0, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 3'b011);
      set_req(1, 16'h0001, 16'h0001, 2'b00);
      req_valid[1] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_out", 32'(resp_out), 32'h8000);
         check("bp_z", 32'(resp_z), 32'd3);
         check("bp_no_grant", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      req_valid  = '0;
      @(posedge clk);
      @(negedge clk);
      check("bp_busy_low", 32'(busy), 32'd0);

      // Reset during EXEC: nothing delivered, pointer back to 0
      @(posedge clk); #1;
      set_req(0, 16'h1234, 16'h00FF, 2'b10);
      set_req(1, 16'h0001, 16'h0002, 2'b00);
      req_valid = 2'b01;
      @(negedge clk);
      check("mid_grant0", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = '0;
      check("mid_in_exec", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      req_valid = 2'b11;
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ptr0", 32'(req_ready), 32'd1);
      begin
         exp_t e;
         e.out = 16'h0034; e.z = 3'b000; e.id = 0;
         sb.push_back(e);
      end
      @(posedge clk); #1 req_valid = '0;
      repeat (3) @(posedge clk); #1;

      // Withdrawn request during RESP is never granted
      resp_ready = 1'b0;
      issue(1, 16'h0002, 16'h0003, 2'b00, 16'h0005, 3'b000);
      req_valid[0] = 1'b1;
      @(negedge clk);
      check("wd_no_grant", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("wd_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      issue(1, 16'h00FF, 16'h0F0F, 2'b10, 16'h000F, 3'b000);

      for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
